// File: rtl/pixel_task_scheduler.sv
// pixel_task_scheduler: walks a width x height pixel grid in raster order,
// issuing one complex-plane coordinate per pixel to an iteration solver and
// forwarding the in-order solver responses as tagged pixel results.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cfg_start                  one-cycle frame start request
//   cfg_x0/y0, cfg_dx/dy       Q8.20 origin and per-column/per-row steps
//   cfg_width/height           frame dimensions in pixels
//   busy, done                 frame in progress / completion pulse
//   solver_cmd_*               coordinate command stream to the solver
//   solver_rsp_*               iteration-count response stream from the solver
//   pix_*                      pixel result stream (iteration, x, y, last)
module pixel_task_scheduler #(
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned DIM_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic [27:0]         cfg_x0,
    input  logic [27:0]         cfg_y0,
    input  logic [27:0]         cfg_dx,
    input  logic [27:0]         cfg_dy,
    input  logic [DIM_W-1:0]    cfg_width,
    input  logic [DIM_W-1:0]    cfg_height,
    output logic                busy,
    output logic                done,
    output logic                solver_cmd_valid,
    input  logic                solver_cmd_ready,
    output logic [27:0]         solver_cmd_payload_x,
    output logic [27:0]         solver_cmd_payload_y,
    input  logic                solver_rsp_valid,
    output logic                solver_rsp_ready,
    input  logic [3:0]          solver_rsp_payload_iteration,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [3:0]          pix_iteration,
    output logic [DIM_W-1:0]    pix_x,
    output logic [DIM_W-1:0]    pix_y,
    output logic                pix_last
);

    localparam int unsigned COORD_W = 28;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]         state_q,    state_d;
    logic [COORD_W-1:0] x0_q,       x0_d;
    logic [COORD_W-1:0] dx_q,       dx_d;
    logic [COORD_W-1:0] dy_q,       dy_d;
    logic [DIM_W-1:0]   width_q,    width_d;
    logic [DIM_W-1:0]   height_q,   height_d;
    logic [COORD_W-1:0] cur_x_q,    cur_x_d;
    logic [COORD_W-1:0] cur_y_q,    cur_y_d;
    logic [DIM_W-1:0]   cmd_col_q,  cmd_col_d;
    logic [DIM_W-1:0]   cmd_row_q,  cmd_row_d;
    logic [DIM_W-1:0]   rsp_col_q,  rsp_col_d;
    logic [DIM_W-1:0]   rsp_row_q,  rsp_row_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               done_q,     done_d;

    logic active;
    logic cmd_fire;
    logic rsp_fire;
    logic cmd_last_col;
    logic cmd_last_row;
    logic rsp_last_col;
    logic rsp_last;

    // Status and handshake decode from the state register
    assign active               = (state_q != S_IDLE);
    assign busy                 = active;
    assign done                 = done_q;
    assign solver_cmd_valid     = (state_q == S_ISSUE) && (inflight_q < MAX_CNT);
    assign solver_cmd_payload_x = cur_x_q;
    assign solver_cmd_payload_y = cur_y_q;

    // Responses pass straight through to the pixel port while a frame is open
    assign pix_valid        = active && solver_rsp_valid;
    assign solver_rsp_ready = active && pix_ready;
    assign pix_iteration    = solver_rsp_payload_iteration;
    assign pix_x            = rsp_col_q;
    assign pix_y            = rsp_row_q;

    assign cmd_fire     = solver_cmd_valid && solver_cmd_ready;
    assign rsp_fire     = pix_valid && pix_ready;
    assign cmd_last_col = (cmd_col_q == width_q - DIM_W'(1));
    assign cmd_last_row = (cmd_row_q == height_q - DIM_W'(1));
    assign rsp_last_col = (rsp_col_q == width_q - DIM_W'(1));
    assign rsp_last     = rsp_last_col && (rsp_row_q == height_q - DIM_W'(1));
    assign pix_last     = active && rsp_last;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            width_q    <= '0;
            height_q   <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            cmd_col_q  <= '0;
            cmd_row_q  <= '0;
            rsp_col_q  <= '0;
            rsp_row_q  <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            width_q    <= width_d;
            height_q   <= height_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            cmd_col_q  <= cmd_col_d;
            cmd_row_q  <= cmd_row_d;
            rsp_col_q  <= rsp_col_d;
            rsp_row_q  <= rsp_row_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    // Next-state, counter and coordinate logic
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        width_d    = width_q;
        height_d   = height_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        cmd_col_d  = cmd_col_q;
        cmd_row_d  = cmd_row_q;
        rsp_col_d  = rsp_col_q;
        rsp_row_d  = rsp_row_q;
        inflight_d = inflight_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start && (cfg_width != '0) && (cfg_height != '0)) begin
                    x0_d      = cfg_x0;
                    dx_d      = cfg_dx;
                    dy_d      = cfg_dy;
                    width_d   = cfg_width;
                    height_d  = cfg_height;
                    cur_x_d   = cfg_x0;
                    cur_y_d   = cfg_y0;
                    cmd_col_d = '0;
                    cmd_row_d = '0;
                    rsp_col_d = '0;
                    rsp_row_d = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_fire && cmd_last_col && cmd_last_row) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Only DRAIN may close a frame, so a 1x1 frame ends here too
                if (rsp_fire && rsp_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Command raster walk; coordinates wrap as 28-bit two's complement
        if (cmd_fire) begin
            if (cmd_last_col) begin
                cur_x_d   = x0_q;
                cur_y_d   = cur_y_q + dy_q;
                cmd_col_d = '0;
                cmd_row_d = cmd_row_q + DIM_W'(1);
            end else begin
                cur_x_d   = cur_x_q + dx_q;
                cmd_col_d = cmd_col_q + DIM_W'(1);
            end
        end

        // Response raster walk mirrors the command walk
        if (rsp_fire) begin
            if (rsp_last_col) begin
                rsp_col_d = '0;
                rsp_row_d = rsp_row_q + DIM_W'(1);
            end else begin
                rsp_col_d = rsp_col_q + DIM_W'(1);
            end
        end

        // Outstanding command count
        case ({cmd_fire, rsp_fire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

endmodule

// File: tb/tb_pixel_task_scheduler.sv
// Scoreboard bench for pixel_task_scheduler: expected commands and pixels are
// queued at frame start from a closed-form raster model; a behavioural solver
// answers commands in order with a bench-chosen iteration sequence.
module tb_pixel_task_scheduler;

    logic        clk;
    logic        reset;
    logic        cfg_start;
    logic [27:0] cfg_x0, cfg_y0, cfg_dx, cfg_dy;
    logic [7:0]  cfg_width, cfg_height;
    logic        busy, done;
    logic        solver_cmd_valid, solver_cmd_ready;
    logic [27:0] solver_cmd_payload_x, solver_cmd_payload_y;
    logic        solver_rsp_valid, solver_rsp_ready;
    logic [3:0]  solver_rsp_payload_iteration;
    logic        pix_valid, pix_ready;
    logic [3:0]  pix_iteration;
    logic [7:0]  pix_x, pix_y;
    logic        pix_last;

    typedef struct packed {
        logic [27:0] x;
        logic [27:0] y;
    } cmd_t;

    typedef struct packed {
        logic [7:0] px;
        logic [7:0] py;
        logic       last;
        logic [3:0] it;
    } pix_t;

    cmd_t       exp_cmd[$];
    pix_t       exp_pix[$];
    logic [3:0] sfifo[$];

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   cmd_fires = 0;
    int   s_cnt = 0;
    bit   rsp_en = 1'b1;
    bit   toggle_mode = 1'b0;
    bit   stall_prev = 1'b0;
    logic [27:0] stall_x, stall_y;

    pixel_task_scheduler #(.MAX_INFLIGHT(8), .DIM_W(8)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .cfg_start                    (cfg_start),
        .cfg_x0                       (cfg_x0),
        .cfg_y0                       (cfg_y0),
        .cfg_dx                       (cfg_dx),
        .cfg_dy                       (cfg_dy),
        .cfg_width                    (cfg_width),
        .cfg_height                   (cfg_height),
        .busy                         (busy),
        .done                         (done),
        .solver_cmd_valid             (solver_cmd_valid),
        .solver_cmd_ready             (solver_cmd_ready),
        .solver_cmd_payload_x         (solver_cmd_payload_x),
        .solver_cmd_payload_y         (solver_cmd_payload_y),
        .solver_rsp_valid             (solver_rsp_valid),
        .solver_rsp_ready             (solver_rsp_ready),
        .solver_rsp_payload_iteration (solver_rsp_payload_iteration),
        .pix_valid                    (pix_valid),
        .pix_ready                    (pix_ready),
        .pix_iteration                (pix_iteration),
        .pix_x                        (pix_x),
        .pix_y                        (pix_y),
        .pix_last                     (pix_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive solver side at negedge, then score handshakes
    task automatic step();
        cmd_t c;
        pix_t p;
        @(negedge clk);
        solver_cmd_ready = toggle_mode ? ~solver_cmd_ready : 1'b1;
        solver_rsp_valid = rsp_en && (sfifo.size() != 0);
        solver_rsp_payload_iteration = (sfifo.size() != 0) ? sfifo[0] : 4'd0;
        #1;
        if (stall_prev) begin
            total++;
            if (solver_cmd_valid !== 1'b1 || solver_cmd_payload_x !== stall_x ||
                solver_cmd_payload_y !== stall_y) begin
                bad++;
                $display("FAIL stall_hold: got v=%b x=%h y=%h want v=1 x=%h y=%h",
                         solver_cmd_valid, solver_cmd_payload_x, solver_cmd_payload_y,
                         stall_x, stall_y);
            end
        end
        stall_prev = (solver_cmd_valid === 1'b1) && (solver_cmd_ready === 1'b0);
        stall_x = solver_cmd_payload_x;
        stall_y = solver_cmd_payload_y;
        if (solver_cmd_valid === 1'b1 && solver_cmd_ready === 1'b1) begin
            cmd_fires++;
            total++;
            if (exp_cmd.size() == 0) begin
                bad++;
                $display("FAIL cmd_unexpected: got x=%h y=%h want none",
                         solver_cmd_payload_x, solver_cmd_payload_y);
            end else begin
                c = exp_cmd.pop_front();
                if ({solver_cmd_payload_x, solver_cmd_payload_y} !== c) begin
                    bad++;
                    $display("FAIL cmd_payload: got x=%h y=%h want x=%h y=%h",
                             solver_cmd_payload_x, solver_cmd_payload_y, c.x, c.y);
                end
            end
            sfifo.push_back(4'(s_cnt * 7 + 3));
            s_cnt++;
        end
        if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
            total++;
            if (sfifo.size() != 0) void'(sfifo.pop_front());
            if (exp_pix.size() == 0) begin
                bad++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d want none", pix_x, pix_y);
            end else begin
                p = exp_pix.pop_front();
                if ({pix_x, pix_y, pix_last, pix_iteration} !== p) begin
                    bad++;
                    $display("FAIL pix_result: got x=%0d y=%0d last=%b it=%0d want x=%0d y=%0d last=%b it=%0d",
                             pix_x, pix_y, pix_last, pix_iteration, p.px, p.py, p.last, p.it);
                end
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL done_busy: got busy=%b want 0", busy);
            end
        end
    endtask

    // Program a frame, queue its expected traffic, pulse start
    task automatic start_frame(input logic [27:0] x0, input logic [27:0] y0,
                               input logic [27:0] dx, input logic [27:0] dy,
                               input int w, input int h);
        int base;
        int idx;
        base = s_cnt;
        idx = 0;
        cfg_x0 = x0; cfg_y0 = y0; cfg_dx = dx; cfg_dy = dy;
        cfg_width = 8'(w); cfg_height = 8'(h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                exp_cmd.push_back({28'(x0 + 28'(c * dx)), 28'(y0 + 28'(r * dy))});
                exp_pix.push_back({8'(c), 8'(r), (c == w - 1) && (r == h - 1),
                                   4'((base + idx) * 7 + 3)});
                idx++;
            end
        end
        done_cnt = 0;
        cmd_fires = 0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    // Run until every expectation is consumed and done seen, then audit
    task automatic finish_frame(input int budget);
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_pix.size() != 0 || done_cnt == 0) && n < budget) begin
            step();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL frame_timeout: got cmd_left=%0d pix_left=%0d done=%0d want 0 0 1",
                     exp_cmd.size(), exp_pix.size(), done_cnt);
        end
        repeat (3) step();
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL done_count: got %0d want 1", done_cnt);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_frame: got %b want 0", busy);
        end
        exp_cmd.delete();
        exp_pix.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if ({busy, done, solver_cmd_valid, solver_rsp_ready, pix_valid, pix_last} !== 6'b0) begin
            bad++;
            $display("FAIL %s: got busy,done,cv,rr,pv,pl=%b want 000000", name,
                     {busy, done, solver_cmd_valid, solver_rsp_ready, pix_valid, pix_last});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cfg_start = 1'b0;
        cfg_x0 = '0; cfg_y0 = '0; cfg_dx = '0; cfg_dy = '0;
        cfg_width = '0; cfg_height = '0;
        solver_cmd_ready = 1'b1;
        solver_rsp_valid = 1'b0;
        solver_rsp_payload_iteration = '0;
        pix_ready = 1'b1;
        step();
        step();
        check_idle_outputs("reset_state");
        reset = 1'b0;
        step();
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_basic_2x2();
        start_frame(28'h0, 28'h0, 28'h0100000, 28'h0100000, 2, 2);
        finish_frame(100);
    endtask

    task automatic test_shapes();
        start_frame(28'h0000123, 28'h0, 28'h0, 28'h0, 1, 1);
        finish_frame(50);
        start_frame(28'h0200000, 28'hFE00000, 28'hFF00000, 28'h0, 3, 1);
        finish_frame(50);
        start_frame(28'h0, 28'h0080000, 28'h0, 28'hFFC0000, 1, 3);
        finish_frame(50);
        start_frame(28'hE000000, 28'hF000000, 28'h0001234, 28'h0004321, 5, 4);
        finish_frame(200);
    endtask

    task automatic test_inflight_limit();
        rsp_en = 1'b0;
        start_frame(28'h0, 28'h0, 28'h0100000, 28'h0100000, 4, 4);
        repeat (20) step();
        total++;
        if (cmd_fires !== 8) begin
            bad++;
            $display("FAIL inflight_cap: got %0d commands want 8", cmd_fires);
        end
        total++;
        if (solver_cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL inflight_valid_low: got %b want 0", solver_cmd_valid);
        end
        rsp_en = 1'b1;
        step();
        rsp_en = 1'b0;
        repeat (6) step();
        total++;
        if (cmd_fires !== 9) begin
            bad++;
            $display("FAIL inflight_release: got %0d commands want 9", cmd_fires);
        end
        rsp_en = 1'b1;
        finish_frame(200);
    endtask

    task automatic test_back_to_back_stall();
        toggle_mode = 1'b1;
        start_frame(28'h0100000, 28'h0300000, 28'h0100000, 28'h0100000, 3, 3);
        finish_frame(300);
        toggle_mode = 1'b0;
        solver_cmd_ready = 1'b1;
        stall_prev = 1'b0;
    endtask

    task automatic test_ignored_starts();
        cfg_width = 8'd0;
        cfg_height = 8'd3;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        repeat (3) step();
        total++;
        if (busy !== 1'b0 || solver_cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_width_start: got busy=%b cv=%b want 0 0", busy, solver_cmd_valid);
        end
        start_frame(28'h0, 28'h0, 28'h0100000, 28'h0100000, 3, 2);
        step();
        cfg_x0 = 28'h5555555; cfg_dx = 28'h0000007;
        cfg_width = 8'd9; cfg_height = 8'd9;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        finish_frame(200);
    endtask

    task automatic test_wrap();
        start_frame(28'h7FFFFFF, 28'h7FFFFFF, 28'h0000001, 28'h0000001, 2, 2);
        finish_frame(100);
    endtask

    task automatic test_reset_midframe();
        int n;
        rsp_en = 1'b0;
        start_frame(28'h0, 28'h0, 28'h0100000, 28'h0100000, 3, 3);
        n = 0;
        while (cmd_fires < 3 && n < 50) begin
            step();
            n++;
        end
        total++;
        if (cmd_fires !== 3) begin
            bad++;
            $display("FAIL midframe_cmds: got %0d want 3", cmd_fires);
        end
        reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        exp_cmd.delete();
        exp_pix.delete();
        sfifo.delete();
        stall_prev = 1'b0;
        rsp_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        total++;
        if (done_cnt !== 0) begin
            bad++;
            $display("FAIL abandoned_done: got %0d pulses want 0", done_cnt);
        end
        start_frame(28'h0010000, 28'h0020000, 28'h0100000, 28'h0100000, 3, 2);
        finish_frame(100);
    endtask

    initial begin
        test_reset();
        test_basic_2x2();
        test_shapes();
        test_inflight_limit();
        test_back_to_back_stall();
        test_ignored_starts();
        test_wrap();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_task_scheduler.md
PIXEL_TASK_SCHEDULER -- requirements
Module: pixel_task_scheduler

Interface
REQ-001 Parameter MAX_INFLIGHT, default 8: maximum solver commands accepted but not yet answered; must be 1..8, matching the solver's 3-bit context ID space.
REQ-002 Parameter DIM_W, default 8: width of the frame dimension and pixel coordinate fields.
REQ-003 The block SHALL have one clock, clk, and an asynchronous, active-high reset, reset.
REQ-004 Ports, as name  direction  width  meaning:
- clk  in  1  clock
- reset  in  1  async active-high reset
- cfg_start  in  1  one-cycle frame start request
- cfg_x0  in  28  signed Q8.20 real coordinate of pixel (0,0)
- cfg_y0  in  28  signed Q8.20 imaginary coordinate of pixel (0,0)
- cfg_dx  in  28  signed Q8.20 step per column
- cfg_dy  in  28  signed Q8.20 step per row
- cfg_width  in  DIM_W  pixels per row
- cfg_height  in  DIM_W  rows per frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse on frame completion
- solver_cmd_valid  out  1  command handshake valid
- solver_cmd_ready  in  1  command handshake ready
- solver_cmd_payload_x  out  28  command real coordinate
- solver_cmd_payload_y  out  28  command imaginary coordinate
- solver_rsp_valid  in  1  response handshake valid
- solver_rsp_ready  out  1  response handshake ready
- solver_rsp_payload_iteration  in  4  response iteration count
- pix_valid  out  1  pixel result valid
- pix_ready  in  1  pixel result ready
- pix_iteration  out  4  pixel iteration count
- pix_x  out  DIM_W  pixel column
- pix_y  out  DIM_W  pixel row
- pix_last  out  1  final pixel of the frame

Function
REQ-005 FSM states: IDLE, ISSUE, DRAIN.
REQ-006 IDLE -> ISSUE on cfg_start=1 with cfg_width!=0 and cfg_height!=0: latch all cfg_* inputs; clear command and response column/row counters; load cmd coordinate with (cfg_x0, cfg_y0).
REQ-007 cfg_start SHALL be ignored when either dimension is 0, and in ISSUE or DRAIN.
REQ-008 busy=1 exactly in ISSUE and DRAIN; solver_cmd_valid is first asserted the cycle after start is accepted.
REQ-009 In ISSUE: solver_cmd_valid = (inflight < MAX_INFLIGHT); payload = current coordinate register; payload stable while valid && !ready.
REQ-010 On cmd accept (valid && ready):
- not last column: x += dx, col += 1;
- last column: x reloads latched x0, y += dy, col = 0, row += 1.
REQ-011 Coordinate arithmetic SHALL be 28-bit two's complement, wrapping silently on overflow.
REQ-012 When the command for (width-1, height-1) is accepted, FSM -> DRAIN; solver_cmd_valid=0 in DRAIN and IDLE.
REQ-013 inflight counter, range 0..MAX_INFLIGHT: +1 on cmd accept, -1 on rsp accept, unchanged when both occur in one cycle.
REQ-014 Solver responses arrive in command order. Forwarding is combinational, zero latency, in ISSUE and DRAIN:
- pix_valid = solver_rsp_valid;
- solver_rsp_ready = pix_ready;
- pix_iteration = solver_rsp_payload_iteration;
- pix_x / pix_y = response column / row counters.
REQ-015 In IDLE: pix_valid=0 and solver_rsp_ready=0.
REQ-016 On response accept, the response counters advance in raster order, using the same wrap rules as the command counters.
REQ-017 pix_last=1 when the response counters equal (width-1, height-1).
REQ-018 Accepting the pix_last response SHALL return the FSM to IDLE and pulse done for exactly that one cycle.
- For a 1x1 frame this may happen while the FSM is still in DRAIN.
- The FSM SHALL never end the frame from ISSUE.
REQ-019 cfg_* changes while busy SHALL have no effect on the current frame.

Reset
REQ-020 Asserting reset SHALL force, asynchronously:
- state=IDLE; busy=0; done=0;
- solver_cmd_valid=0; solver_rsp_ready=0; pix_valid=0; pix_last=0;
- inflight=0; all counters and the coordinate register = 0.
REQ-021 Reset mid-frame SHALL abandon the frame with no done pulse.
- The solver shares clk and reset, so no stale responses survive.

Verification
REQ-022 2x2 frame: x0=0, y0=0, dx=dy=0x0100000 (1.0), all ready=1 -> commands (0,0), (0x100000,0), (0,0x100000), (0x100000,0x100000); pix (0,0),(1,0),(0,1),(1,1); pix_last only on (1,1); one done pulse.
REQ-023 Inflight limit: 4x4 frame, rsp_valid held 0 -> exactly 8 commands accepted, then solver_cmd_valid=0; releasing one response allows exactly one more command.
REQ-024 Backpressure: solver_cmd_ready toggled 0/1 every cycle -> payload constant while stalled; command sequence identical to the no-stall run.
REQ-025 Ignored starts: cfg_width=0 with cfg_start -> busy stays 0; cfg_start pulsed during a frame -> frame unaffected, exactly one done pulse.
REQ-026 Wrap: x0=0x7FFFFFF, dx=1, width=2 -> second command x = 0x8000000.
REQ-027 Reset mid-frame after 3 commands -> all outputs at reset values within the same cycle; the next start runs a full frame correctly.
